// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the I/D main-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned LINEWORDS_DEF = 4;
  localparam int unsigned AW_DEF        = 27;

  localparam logic       MEM_READ   = 1'b1;
  localparam logic       MEM_WRITE  = 1'b0;
  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFILL  = 3'd1,
    DFILL  = 3'd2,
    DWRITE = 3'd3,
    GAP    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arbiter_beatctr.sv
// Beat counter within one line fill: clear on grant, increment per completed beat.
module mem_arbiter_beatctr #(
  parameter int unsigned LINEWORDS = 4,
  parameter int unsigned CW        = (LINEWORDS > 1) ? $clog2(LINEWORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_c_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign last_c_o = (cnt_q == CW'(LINEWORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared main-memory port between I-side line fills and D-side fills/writes.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating priority; default is fixed D-over-I.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LINEWORDS = LINEWORDS_DEF,
  parameter int unsigned AW        = AW_DEF
) (
  input  logic          ph1,
  input  logic          resetb,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [31:0]   irdata,
  output logic          ivalid,
  output logic          idone,
  input  logic          dreq,
  input  logic          drwb,
  input  logic [AW-1:0] dadr,
  input  logic [31:0]   dwdata,
  input  logic [3:0]    dbyteen,
  output logic [31:0]   drdata,
  output logic          dvalid,
  output logic          ddone,
  output logic [AW-1:0] memadr,
  output logic [31:0]   memwdata,
  input  logic [31:0]   memrdata,
  output logic [3:0]    membyteen,
  output logic          memrwb,
  output logic          memen,
  input  logic          memdone
);

  localparam int unsigned   CW       = (LINEWORDS > 1) ? $clog2(LINEWORDS) : 1;
  localparam logic [AW-1:0] OFS_MASK = AW'(LINEWORDS - 1);

  state_e        state_q, state_d, ret_q, ret_d;
  logic [AW-1:0] base_q, base_d, memadr_q, memadr_d;
  logic [31:0]   memwdata_q, memwdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
  logic [3:0]    membyteen_q, membyteen_d;
  logic          memrwb_q, memrwb_d, memen_q, memen_d;
  logic          ivalid_q, ivalid_d, idone_q, idone_d;
  logic          dvalid_q, dvalid_d, ddone_q, ddone_d;
  logic          ctr_clr, ctr_inc, ctr_last_c;
  logic [CW-1:0] ctr_cnt;
  logic          d_wins_c, grant_c;

  mem_arbiter_beatctr #(.LINEWORDS(LINEWORDS), .CW(CW)) u_beatctr (
    .clk      (ph1),
    .rst_n    (resetb),
    .clr_i    (ctr_clr),
    .inc_i    (ctr_inc),
    .cnt_o    (ctr_cnt),
    .last_c_o (ctr_last_c)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_d_q = 1 when D held the most recent grant; the other side wins a tie
  logic last_d_q, last_d_d;
  assign d_wins_c = dreq && (!ireq || !last_d_q);
`else
  assign d_wins_c = dreq;
`endif

  // The done cycle is spent in IDLE without granting so a held req is not re-served
  assign grant_c = (state_q == IDLE) && !(idone_q || ddone_q) && (ireq || dreq);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    base_d      = base_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    membyteen_d = membyteen_q;
    memrwb_d    = memrwb_q;
    memen_d     = memen_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    ivalid_d    = 1'b0;
    idone_d     = 1'b0;
    dvalid_d    = 1'b0;
    ddone_d     = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          ctr_clr     = 1'b1;
          memen_d     = 1'b1;
          memrwb_d    = MEM_READ;
          membyteen_d = BYTEEN_ALL;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_d_d    = d_wins_c;
`endif
          if (!d_wins_c) begin
            state_d = IFILL;
            base_d  = iadr & ~OFS_MASK;
          end else if (drwb) begin
            state_d = DFILL;
            base_d  = dadr & ~OFS_MASK;
          end else begin
            state_d     = DWRITE;
            base_d      = dadr;
            memwdata_d  = dwdata;
            membyteen_d = dbyteen;
            memrwb_d    = MEM_WRITE;
          end
          memadr_d = base_d;
        end
      end
      IFILL, DFILL, DWRITE: begin
        if (memen_q && memdone) begin
          memen_d = 1'b0;
          if (state_q == IFILL) begin
            irdata_d = memrdata;
            ivalid_d = 1'b1;
          end
          if (state_q == DFILL) begin
            drdata_d = memrdata;
            dvalid_d = 1'b1;
          end
          if ((state_q == DWRITE) || ctr_last_c) begin
            idone_d     = (state_q == IFILL);
            ddone_d     = (state_q != IFILL);
            state_d     = IDLE;
            memrwb_d    = MEM_READ;
            membyteen_d = BYTEEN_ALL;
          end else begin
            ctr_inc = 1'b1;
            ret_d   = state_q;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        // Return-to-zero cycle; the counter already points at the next beat
        state_d  = ret_q;
        memen_d  = 1'b1;
        memadr_d = base_q | AW'(ctr_cnt);
      end
      default: begin
        state_d = IDLE;
        memen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      base_q      <= '0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      membyteen_q <= BYTEEN_ALL;
      memrwb_q    <= MEM_READ;
      memen_q     <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      idone_q     <= 1'b0;
      dvalid_q    <= 1'b0;
      ddone_q     <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      base_q      <= base_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      membyteen_q <= membyteen_d;
      memrwb_q    <= memrwb_d;
      memen_q     <= memen_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      ivalid_q    <= ivalid_d;
      idone_q     <= idone_d;
      dvalid_q    <= dvalid_d;
      ddone_q     <= ddone_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign memadr    = memadr_q;
  assign memwdata  = memwdata_q;
  assign membyteen = membyteen_q;
  assign memrwb    = memrwb_q;
  assign memen     = memen_q;
  assign irdata    = irdata_q;
  assign ivalid    = ivalid_q;
  assign idone     = idone_q;
  assign drdata    = drdata_q;
  assign dvalid    = dvalid_q;
  assign ddone     = ddone_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared main-memory port between the instruction-fill path and the data path (D-side line fills and single-word write-throughs).
- Sequences multi-beat line reads and returns data one word per beat.
- Sits between the I/D caches and mainmem, on the memadr/membyteen/memrwb/memen/memdone interface.

Parameters:
LINEWORDS, 4, words per line fill; power of 2, >= 1
AW, 27, word-address width of the memory port

Ports:
ph1  input  1  clock; all state updates on posedge ph1
resetb  input  1  asynchronous active-low reset
ireq  input  1  I-side line-fill request; level, held until idone
iadr  input  AW  I-side word address; low log2(LINEWORDS) bits ignored
irdata  output  32  I-side returned word
ivalid  output  1  irdata valid this cycle
idone  output  1  one-cycle pulse on the last I beat
dreq  input  1  D-side request; level, held until ddone
drwb  input  1  D-side direction: 1 = line read, 0 = single-word write
dadr  input  AW  D-side word address
dwdata  input  32  D-side write data
dbyteen  input  4  D-side byte enables for writes
drdata  output  32  D-side returned word
dvalid  output  1  drdata valid this cycle
ddone  output  1  one-cycle pulse on the last D beat, or on write completion
memadr  output  AW  memory word address
memwdata  output  32  memory write data
memrdata  input  32  memory read data
membyteen  output  4  memory byte enables
memrwb  output  1  1 = read, 0 = write
memen  output  1  memory access strobe
memdone  input  1  memory beat complete; memrdata valid in the same cycle

Behaviour:
- Reset (resetb low, asynchronous):
  - State = IDLE.
  - All outputs 0, except memrwb = 1 and membyteen = 4'b1111.
  - Beat counter = 0.
- States: IDLE, IFILL, DFILL, DWRITE, GAP.
- IDLE:
  - If dreq && ireq, choose by priority (see Optional Feature).
  - If only one request is high, grant that requester.
  - On grant:
    - Capture the address with its low log2(LINEWORDS) bits zeroed (DWRITE keeps the full address).
    - Capture dwdata/dbyteen for writes.
    - Clear the beat counter.
    - Next state: IFILL, DFILL (drwb = 1) or DWRITE (drwb = 0).
- Busy states (IFILL/DFILL/DWRITE):
  - memen = 1; memadr = captured base | beat count; memrwb = 1 for fills, 0 for DWRITE.
  - membyteen = dbyteen in DWRITE, 4'b1111 otherwise.
  - Latency: memen first high the cycle after the request is sampled in IDLE.
- Beat completion (cycle where memen && memdone):
  - Fills: the next cycle drives rdata = captured memrdata, valid = 1 for one cycle to the owning requester.
  - Beat counter increments. It wraps only within the line; base high bits never change.
  - After a non-final beat, go to GAP: memen = 0 for exactly one cycle (return-to-zero handshake), then back to the same busy state.
  - Final beat (count = LINEWORDS-1, or any DWRITE beat): done pulses together with the final valid (writes: done only), then go to IDLE.
- After done:
  - The requester must drop req in the cycle following done.
  - The arbiter spends at least one cycle in IDLE after every transaction, so a req still high there is a new request.
- Request dropped mid-transaction: ignored; the transaction runs to completion and the done pulse is still issued.
- Signals held stable while busy: captured address/data, so iadr/dadr/dwdata may change after grant.
- Mutual exclusion: ivalid/dvalid and idone/ddone are never asserted simultaneously.
- memdone while memen = 0 (IDLE/GAP): ignored.
- LINEWORDS = 1: no GAP state is ever entered.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last-grant flag (reset = I) alternates priority on simultaneous requests: the side not granted last wins.
  - A single requester is always granted immediately.
- Undefined: fixed priority, D over I, on simultaneous requests.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE, IFILL, DFILL, DWRITE, GAP).
  - LINEWORDS/AW defaults.
  - memrwb read/write encoding constants.
- One sub-module is natural: mem_arbiter_beatctr.
  - log2(LINEWORDS)-bit counter with clear, increment and last-beat flag.

Test Plan:
- I fill alone: LINEWORDS = 4, ireq with iadr = 27'h000013.
  - memadr = 0x10, 0x11, 0x12, 0x13, with one memen-low cycle between beats.
  - 4 ivalid pulses carrying memrdata values; idone with the 4th.
- D write: drwb = 0, dadr = 0x25, dwdata = 32'hDEADBEEF, dbyteen = 4'b0011.
  - One beat: memrwb = 0, memadr = 0x25, membyteen = 4'b0011.
  - ddone pulse; no dvalid.
- Simultaneous ireq/dreq, macro undefined: D granted first, then I after one IDLE cycle. Repeat: D wins again.
- Simultaneous ireq/dreq, macro defined: first grant D (last-grant reset = I), next simultaneous grant I, then D.
- Mid-operation events:
  - resetb low during beat 2 of DFILL: memen = 0 and state IDLE immediately; no ddone.
  - ireq dropped during a fill: all 4 beats plus idone still issued.
- memdone stall: memdone held low for 10 cycles on beat 0.
  - memen and memadr stay stable throughout.
  - No valid until memdone arrives.
